fetch_decode_queue: RTL
=======================

// Module: fetch_decode_queue
// PURPOSE
//  Instruction queue between the fetch cycle and the decode stage. It captures each fetched
//  {ir, currpc, newpc} triple, buffers up to DEPTH entries, and presents them in order to
//  decode over a valid/ready handshake. It drives pcwrite back to the PC register so fetch
//  stalls when the queue is full. A flush discards all buffered entries on a branch/jump.
// PARAMETERS
//  DEPTH  2   number of entries; power of two, >= 2
//  W      16  instruction/PC width
// PORTS
//  clk         in   1    single clock; all state updates on rising edge
//  rst         in   1    asynchronous, active-low reset
//  in_valid    in   1    fetch presents a valid triple this cycle
//  in_ir       in   W    fetched instruction word
//  in_currpc   in   W    PC of in_ir
//  in_newpc    in   W    sequential next PC (in_currpc + 2)
//  pcwrite     out  1    accept/advance: high when the queue can take an entry (== !full)
//  flush       in   1    synchronous discard of all entries (taken branch/jump)
//  out_valid   out  1    head entry valid
//  out_ready   in   1    decode consumes the head this cycle
//  out_ir      out  W    head instruction; 16'h0000 when out_valid=0
//  out_currpc  out  W    head PC; 16'h0000 when out_valid=0
//  out_newpc   out  W    head next PC; 16'h0000 when out_valid=0
//  count       out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (rst=0, async): rd_ptr=wr_ptr=0, count=0, out_valid=0, out_* = 0, pcwrite=1.
//    Storage contents are don't-care and are never visible while empty.
//  - push = in_valid & pcwrite & !flush; pop = out_valid & out_ready & !flush.
//  - pcwrite = (count < DEPTH). It is a function of registered count only, with no
//    combinational path from out_ready. A full queue does not accept an entry even when
//    a pop occurs in the same cycle.
//  - Latency: an entry pushed at edge N appears on out_* after edge N. The earliest pop is
//    the cycle after the push; there is no fall-through.
//  - Order: strict FIFO. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both
//    pointers advance.
//  - count: +1 on push only, -1 on pop only. It never exceeds DEPTH and never underflows.
//  - Empty: out_valid=0, out_* forced to 0. out_ready is ignored while empty.
//  - Full: pcwrite=0. in_valid is ignored, and fetch must hold its PC.
//  - Flush (sync, priority over push and pop): on the next edge count=0, pointers=0,
//    out_valid=0. Any push or pop in the flush cycle is discarded.
//  - Reset asserted mid-operation: state clears immediately and asynchronously. Release is
//    synchronous to clk, and the first push is accepted on the first edge after release.
//  - Data is not checked. newpc is carried through unmodified; the queue never recomputes it.
//  - State (2 states, derived from count): EMPTY (count=0) and NONEMPTY (count>0).
//    EMPTY->NONEMPTY on push.
//    NONEMPTY->EMPTY on pop with count=1 and no push, or on flush.
// STRUCTURE
//  - Shared package/header (proc_defs): WORD_W=16, PC_STEP=2, and a NOP/zero constant
//    16'h0000.
//  - One sub-module, fdq_storage: a DEPTH x (3*W) register array with write port
//    (we, waddr, wdata) and combinational read port (raddr -> rdata). The top level holds
//    the pointers, the count, the handshake logic and the output masking.
// TESTING
//  1. Reset: hold rst=0 with in_valid=1 -> out_valid=0, count=0, pcwrite=1, out_ir=0.
//     Release -> first entry is accepted on the next edge.
//  2. Fill: push ir=16'h1111/pc=0, then ir=16'h2222/pc=2, with out_ready=0 ->
//     count=2, pcwrite=0. A third push of 16'h3333 is ignored, and out_ir stays 16'h1111.
//  3. Drain: from test 2, raise out_ready -> 16'h1111 then 16'h2222 (newpc 2 then 4) on
//     successive cycles, then out_valid=0, out_ir=0.
//  4. Streaming: continuous in_valid and out_ready with pc 0,2,4,...,30 -> count stays 1
//     after the first edge. Output order matches input with no gaps or duplicates, and the
//     pointers wrap correctly.
//  5. Flush: count=2 and flush=1 together with in_valid=1 (ir=16'hBEEF) and out_ready=1 ->
//     next cycle count=0, out_valid=0. 16'hBEEF is never presented, and no entry is popped
//     to decode.
//  6. Mid-operation reset: count=1, then pulse rst low between edges -> out_valid drops
//     without waiting for a clock edge. The post-reset push of 16'h4444 is the next output.

Source files
------------

// File: rtl/fetch_decode_queue_pkg.sv
// Shared definitions for the fetch/decode instruction queue.
//  WORD_W   : instruction / PC width
//  PC_STEP  : sequential PC increment (used by fetch to form newpc)
//  NOP_WORD : value shown on the queue outputs while it is empty
package fetch_decode_queue_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned PC_STEP = 2;
    localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

    // One fetched triple as it travels from fetch to decode.
    typedef struct packed {
        logic [WORD_W-1:0] ir;
        logic [WORD_W-1:0] currpc;
        logic [WORD_W-1:0] newpc;
    } fdq_entry_t;

    // Queue occupancy state; mirrors count==0 / count>0.
    typedef enum logic {
        ST_EMPTY    = 1'b0,
        ST_NONEMPTY = 1'b1
    } fdq_state_e;

endpackage

// File: rtl/fetch_decode_queue_storage.sv
// Entry storage for the fetch/decode queue: DEPTH x DATA_W register array.
//  clk   : write clock
//  we    : write enable, waddr/wdata : write port
//  raddr : read address, rdata : combinational read data
// Contents are not reset; the top level never exposes them while empty.
module fdq_storage #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 48
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read port.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode.
//  clk, rst (async, active-low)
//  in_valid/in_ir/in_currpc/in_newpc : triple offered by fetch
//  pcwrite                           : queue can accept (not full); stalls the PC when low
//  flush                             : discard all entries on the next edge
//  out_valid/out_ready               : head handshake towards decode
//  out_ir/out_currpc/out_newpc       : head triple, zero while empty
//  count                             : current occupancy
// All outputs decode registered state only; nothing combinational from in_* or out_ready.
module fetch_decode_queue
    import fetch_decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = WORD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_ir,
    input  logic [W-1:0]           in_currpc,
    input  logic [W-1:0]           in_newpc,
    output logic                   pcwrite,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_ir,
    output logic [W-1:0]           out_currpc,
    output logic [W-1:0]           out_newpc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned DATA_W = 3 * W;

    fdq_state_e       state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              push_c;
    logic              pop_c;
    logic [DATA_W-1:0] rdata;

    // Handshake decode from registered state only; a full queue never accepts, even on a pop.
    assign pcwrite   = (count_q < CNT_W'(DEPTH));
    assign out_valid = (state_q == ST_NONEMPTY);
    assign push_c    = in_valid & pcwrite & ~flush;
    assign pop_c     = out_valid & out_ready & ~flush;
    assign count     = count_q;

    // Next-state: pointers, occupancy and EMPTY/NONEMPTY state; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush) begin
            state_d  = ST_EMPTY;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            unique case (state_q)
                ST_EMPTY: begin
                    if (push_c) begin
                        state_d = ST_NONEMPTY;
                    end
                end
                ST_NONEMPTY: begin
                    if (pop_c && !push_c && (count_q == CNT_W'(1))) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_EMPTY;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fdq_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_storage (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr_q),
        .wdata ({in_ir, in_currpc, in_newpc}),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Head outputs are masked to NOP while empty so stale storage never leaks.
    always_comb begin
        out_ir     = W'(NOP_WORD);
        out_currpc = W'(NOP_WORD);
        out_newpc  = W'(NOP_WORD);
        if (out_valid) begin
            out_ir     = rdata[3*W-1:2*W];
            out_currpc = rdata[2*W-1:W];
            out_newpc  = rdata[W-1:0];
        end
    end

endmodule
